// File: rtl/mul_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin multiplier scheduler.
// Operand width, product width and the pointer wrap function live here.
package mul_sched_pkg;

    localparam int MUL_W    = 32;
    localparam int PROD_W   = 64;
    localparam int ID_MAX_W = 4;    // enough for up to 16 requesters

    typedef struct packed {
        logic [MUL_W-1:0]    a;
        logic [MUL_W-1:0]    b;
        logic [ID_MAX_W-1:0] id;
    } mul_op_t;

    function automatic logic [ID_MAX_W-1:0] rr_next(input logic [ID_MAX_W-1:0] ptr,
                                                    input int n);
        int p;
        p = int'(ptr) + 1;
        if (p >= n) p = 0;
        return ID_MAX_W'(p);
    endfunction

endpackage

// File: rtl/mul_rr_scheduler_arbiter.sv
// Round-robin arbiter: the first asserted request at or after rr_ptr wins,
// wrapping modulo NUM_REQ. The pointer register is owned by the caller.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    winner,
    output logic               any_grant
);

    logic found;

    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign any_grant = found & enable;

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = any_grant && (winner == ID_W'(i));
        end
    end

endmodule

// File: rtl/mul_rr_scheduler.sv
// Shares one external combinational 32x32 multiplier between NUM_REQ lanes
// through a two-stage pipeline: operand register (S1), product register (S2).
module mul_rr_scheduler
    import mul_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_a,
    input  logic [NUM_REQ*32-1:0]  req_b,
    output logic [31:0]            mul_a,
    output logic [31:0]            mul_b,
    input  logic [63:0]            mul_c,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [63:0]            rsp_product,
    output logic                   busy
);

    // Handshakes: a request transfers on an edge with req_valid[i] & req_ready[i];
    // a response transfers on an edge with rsp_valid & rsp_ready. A stalled
    // response keeps rsp_valid, rsp_id and rsp_product unchanged.

    mul_op_t              s1_q;
    logic                 v1, v2;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      winner;
    logic [NUM_REQ-1:0]   grant;
    logic                 any_grant;
    logic                 s1_en, s2_en, arb_en;

    assign s2_en  = !v2 | rsp_ready;
    assign s1_en  = !v1 | s2_en;
    assign arb_en = s1_en & !rst;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .enable    (arb_en),
        .grant     (grant),
        .winner    (winner),
        .any_grant (any_grant)
    );

    assign req_ready = grant;
    assign mul_a     = s1_q.a;
    assign mul_b     = s1_q.b;
    assign rsp_valid = v2;
    assign busy      = v1 | v2;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            rr_ptr      <= '0;
            s1_q        <= '0;
            rsp_id      <= '0;
            rsp_product <= '0;
        end else begin
            if (s2_en) begin
                v2          <= v1;
                rsp_id      <= s1_q.id[ID_W-1:0];
                rsp_product <= mul_c;
            end
            if (s1_en) begin
                v1 <= any_grant;
                // Operands only load on an accept so the multiplier inputs stay quiet.
                if (any_grant) begin
                    s1_q.a  <= req_a[MUL_W*winner +: MUL_W];
                    s1_q.b  <= req_b[MUL_W*winner +: MUL_W];
                    s1_q.id <= ID_MAX_W'(winner);
                    rr_ptr  <= ID_W'(rr_next(ID_MAX_W'(winner), NUM_REQ));
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Bench for mul_rr_scheduler: directed scenarios plus random traffic, with a
// queue-based scoreboard treating the block as a two-deep in-order pipeline.
module tb_mul_rr_scheduler;

    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a, req_b;
    logic [31:0]     mul_a, mul_b;
    logic [63:0]     mul_c;
    logic            rsp_valid, rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [63:0]     rsp_product;
    logic            busy;

    always #5 clk = ~clk;

    assign mul_c = {32'b0, mul_a} * {32'b0, mul_b};

    mul_rr_scheduler #(.NUM_REQ(N)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_product(rsp_product), .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Outstanding ops in acceptance order: {id, a*b}
    logic [IW+63:0] exp_q[$];
    int             ptr_m    = 0;
    bit             acc_last = 1'b0;
    bit             st_prev  = 1'b0;
    logic [IW-1:0]  st_id;
    logic [63:0]    st_prod;

    // Reference: at most two ops in flight; a new op is taken whenever fewer
    // than two are outstanding or the oldest is leaving; an op is presentable
    // on the response port from the edge after its acceptance onward.
    always @(negedge clk) begin : scoreboard
        logic [N-1:0]   exp_ready;
        logic           exp_rv;
        bit             found;
        int             w;
        exp_ready = '0;
        found     = 1'b0;
        w         = 0;
        if (!rst && (exp_q.size() < 2 || rsp_ready)) begin
            for (int k = 0; k < N; k++) begin
                if (!found && req_valid[(ptr_m + k) % N]) begin
                    found = 1'b1;
                    w     = (ptr_m + k) % N;
                end
            end
        end
        if (found) exp_ready[w] = 1'b1;
        exp_rv = (exp_q.size() >= 2) || (exp_q.size() == 1 && !acc_last);

        n_vec++;
        if (req_ready !== exp_ready) begin
            n_err++;
            $display("FAIL sb_req_ready: got %b expected %b at %0t", req_ready, exp_ready, $time);
        end
        n_vec++;
        if (busy !== (exp_q.size() > 0)) begin
            n_err++;
            $display("FAIL sb_busy: got %b expected %0d at %0t", busy, exp_q.size() > 0, $time);
        end
        n_vec++;
        if (rsp_valid !== exp_rv) begin
            n_err++;
            $display("FAIL sb_rsp_valid: got %b expected %b at %0t", rsp_valid, exp_rv, $time);
        end
        if (exp_rv) begin
            n_vec++;
            if ({rsp_id, rsp_product} !== exp_q[0]) begin
                n_err++;
                $display("FAIL sb_rsp_data: got id=%0d p=%h expected id=%0d p=%h at %0t",
                         rsp_id, rsp_product, exp_q[0][IW+63:64], exp_q[0][63:0], $time);
            end
        end
        if (st_prev) begin
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_id !== st_id || rsp_product !== st_prod) begin
                n_err++;
                $display("FAIL sb_stall_stable: got v=%b id=%0d p=%h expected v=1 id=%0d p=%h",
                         rsp_valid, rsp_id, rsp_product, st_id, st_prod);
            end
        end
        st_prev = rsp_valid && !rsp_ready && !rst;
        st_id   = rsp_id;
        st_prod = rsp_product;

        if (rst) begin
            exp_q.delete();
            ptr_m    = 0;
            acc_last = 1'b0;
        end else begin
            if (exp_rv && rsp_ready) void'(exp_q.pop_front());
            if (found) begin
                exp_q.push_back({IW'(w), 64'(req_a[32*w +: 32]) * 64'(req_b[32*w +: 32])});
                ptr_m    = (w + 1) % N;
                acc_last = 1'b1;
            end else begin
                acc_last = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        while (busy && t < 20) begin
            tick();
            t++;
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL drain: busy=%b expected 0 after %0d cycles", busy, t);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        req_a     = {$urandom, $urandom, $urandom, $urandom};
        req_b     = {$urandom, $urandom, $urandom, $urandom};
        tick();
        tick();
        n_vec++;
        if (req_ready !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: ready=%b rsp_valid=%b busy=%b expected 0/0/0",
                     req_ready, rsp_valid, busy);
        end
        n_vec++;
        if (mul_a !== 32'd0 || mul_b !== 32'd0 || rsp_product !== 64'd0 || rsp_id !== '0) begin
            n_err++;
            $display("FAIL reset_data: a=%h b=%h p=%h id=%0d expected all zero",
                     mul_a, mul_b, rsp_product, rsp_id);
        end
        req_valid = '0;
        rst       = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req_a[31:0] = 32'd3;
        req_b[31:0] = 32'd5;
        req_valid   = 4'b0001;
        rsp_ready   = 1'b1;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL single_ready: got %b expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
        n_vec++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1 || mul_a !== 32'd3 || mul_b !== 32'd5) begin
            n_err++;
            $display("FAIL single_s1: v=%b busy=%b a=%0d b=%0d expected 0/1/3/5",
                     rsp_valid, busy, mul_a, mul_b);
        end
        tick();
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_product !== 64'd15) begin
            n_err++;
            $display("FAIL single_rsp: v=%b id=%0d p=%0d expected 1/0/15",
                     rsp_valid, rsp_id, rsp_product);
        end
        tick();
        n_vec++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_idle: busy=%b v=%b expected 0/0", busy, rsp_valid);
        end
    endtask

    task automatic test_all_valid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = 32'(i + 1);
            req_b[32*i +: 32] = 32'd100;
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_vec++;
            if (req_ready !== 4'(1 << (c % N))) begin
                n_err++;
                $display("FAIL all_grant[%0d]: got %b expected %b", c, req_ready, 4'(1 << (c % N)));
            end
            if (c >= 2) begin
                n_vec++;
                if (rsp_valid !== 1'b1 || rsp_id !== IW'((c - 2) % N) ||
                    rsp_product !== 64'((((c - 2) % N) + 1) * 100)) begin
                    n_err++;
                    $display("FAIL all_rsp[%0d]: v=%b id=%0d p=%0d expected 1/%0d/%0d", c,
                             rsp_valid, rsp_id, rsp_product, (c - 2) % N, (((c - 2) % N) + 1) * 100);
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_max();
        logic [31:0] ca[2];
        logic [31:0] cb[2];
        logic [63:0] cp[2];
        int          ci[2];
        ca[0] = 32'hFFFF_FFFF; cb[0] = 32'hFFFF_FFFF; cp[0] = 64'hFFFF_FFFE_0000_0001; ci[0] = 2;
        ca[1] = 32'h0;         cb[1] = 32'hFFFF_FFFF; cp[1] = 64'h0;                   ci[1] = 3;
        for (int j = 0; j < 2; j++) begin
            int t = 0;
            req_a[32*ci[j] +: 32] = ca[j];
            req_b[32*ci[j] +: 32] = cb[j];
            req_valid = 4'(1 << ci[j]);
            rsp_ready = 1'b1;
            @(negedge clk);
            while (!req_ready[ci[j]] && t < 10) begin
                @(negedge clk);
                t++;
            end
            tick();
            req_valid = '0;
            t = 0;
            while (!rsp_valid && t < 10) begin
                tick();
                t++;
            end
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_product !== cp[j] || rsp_id !== IW'(ci[j])) begin
                n_err++;
                $display("FAIL max[%0d]: v=%b id=%0d p=%h expected 1/%0d/%h",
                         j, rsp_valid, rsp_id, rsp_product, ci[j], cp[j]);
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int n_rsp = 0;
        logic [63:0] held;
        rsp_ready = 1'b0;
        req_a[63:32] = $urandom;
        req_b[63:32] = $urandom;
        req_valid = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (req_ready[1]) acc++;
            tick();
            if (acc > 0) begin
                req_a[63:32] = $urandom;
                req_b[63:32] = $urandom;
            end
        end
        n_vec++;
        if (acc !== 2) begin
            n_err++;
            $display("FAIL bp_accepts: got %0d expected 2", acc);
        end
        held = rsp_product;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_product !== held) begin
            n_err++;
            $display("FAIL bp_stalled: ready=%b v=%b p=%h expected 0000/1/%h",
                     req_ready, rsp_valid, rsp_product, held);
        end
        tick();
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_ready[1]) acc++;
            if (rsp_valid && rsp_ready) n_rsp++;
            tick();
            if (c < 3) begin
                req_a[63:32] = $urandom;
                req_b[63:32] = $urandom;
            end else begin
                req_valid = '0;
            end
        end
        n_vec++;
        if (n_rsp !== acc || busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_delivered: got %0d rsp busy=%b expected %0d rsp busy=0", n_rsp, busy, acc);
        end
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        req_a = {$urandom, $urandom, $urandom, $urandom};
        req_b = {$urandom, $urandom, $urandom, $urandom};
        req_valid = 4'b0100;
        @(negedge clk);
        tick();
        req_valid = 4'b0010;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL wrap_skip: got %b expected 0010", req_ready);
        end
        tick();
        req_valid = 4'b1100;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL wrap_next: got %b expected 0100", req_ready);
        end
        tick();
        req_valid = 4'b1000;
        @(negedge clk);
        tick();
        drain();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        req_a[31:0] = $urandom;
        req_b[31:0] = $urandom;
        req_valid = 4'b0001;
        tick();
        tick();
        req_valid = '0;
        n_vec++;
        if (busy !== 1'b1 || rsp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL mid_full: busy=%b v=%b expected 1/1", busy, rsp_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_flushed: v=%b busy=%b expected 0/0", rsp_valid, busy);
        end
        rsp_ready = 1'b1;
        req_a[127:96] = $urandom;
        req_b[127:96] = $urandom;
        req_a[63:32]  = $urandom;
        req_b[63:32]  = $urandom;
        req_valid = 4'b1010;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL mid_ptr: got %b expected 0010", req_ready);
        end
        tick();
        req_valid = 4'b1000;
        @(negedge clk);
        tick();
        drain();
    endtask

    task automatic test_random();
        logic [N-1:0] acc;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            tick();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) req_valid[i] = 1'($urandom_range(0, 1));
                else if (!req_valid[i]) req_valid[i] = ($urandom_range(0, 2) == 0);
                if (acc[i] || !req_valid[i]) begin
                    req_a[32*i +: 32] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                    req_b[32*i +: 32] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        drain();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_all_valid();
        test_max();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
